dds_sweep_controller: RTL and testbench
=======================================

# dds_sweep_controller

Sequences the frequency control word (FCW) driven into the DDS phase accumulator, producing programmable linear frequency sweeps (chirps).
- Software loads start/stop FCW, step size and step interval through a valid/ready handshake, then issues `start`.
- The block ramps `fcw` by `step` every `interval+1` clocks, either once (single) or continuously up/down (triangle).
- It sits between the configuration interface and the accumulator's FCW input.

## Interface
- `FCW_W`, 24, width of every FCW quantity (matches accumulator FCW/phase width)
- `DIV_W`, 16, width of step-interval counter
- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cfg_valid`  in  1  configuration word valid
- `cfg_ready`  out  1  high only in IDLE; transfer when `cfg_valid & cfg_ready`
- `cfg_start_fcw`  in  FCW_W  sweep lower bound
- `cfg_stop_fcw`  in  FCW_W  sweep upper bound
- `cfg_step`  in  FCW_W  FCW increment per step
- `cfg_interval`  in  DIV_W  clocks between steps minus one
- `cfg_mode`  in  1  0 = single up-sweep, 1 = continuous triangle
- `start`  in  1  begin sweep (sampled in IDLE only)
- `abort`  in  1  stop sweep immediately
- `fcw`  out  FCW_W  registered FCW to phase accumulator
- `fcw_update`  out  1  one-cycle pulse whenever `fcw` changes value or is (re)loaded
- `busy`  out  1  high in UP/DOWN states
- `done`  out  1  one-cycle pulse at end of single sweep

## Operation
- States: IDLE, UP, DOWN.
- **IDLE**
  - `cfg_ready`=1. A handshake latches all cfg fields into internal registers.
  - `start`=1 (with `abort`=0) → load `fcw`=start_fcw, clear interval counter, go to UP.
  - A `start` asserted on the same cycle as a cfg handshake uses the new config.
- **UP**
  - Interval counter counts 0..interval. On reaching interval it wraps to 0 and a step occurs.
  - Step uses FCW_W+1-bit sum `fcw+step`. If sum ≥ stop_fcw, `fcw`=stop_fcw (clamp, no overshoot); otherwise `fcw`=sum.
  - When `fcw` becomes stop_fcw:
    - mode 0: go to IDLE, pulse `done` that same cycle, hold `fcw`.
    - mode 1: go to DOWN.
- **DOWN**
  - Steps at the same cadence. If `fcw` ≤ start_fcw+step, `fcw`=start_fcw (clamp; no underflow); otherwise `fcw`=fcw−step.
  - When `fcw` becomes start_fcw, go to UP. Triangle repeats until `abort`.
- **abort** (any state)
  - Next state IDLE, `fcw` holds its current value, no `done`, no `fcw_update`.
  - `abort` has priority over `start` and over a step on the same cycle.
- Boundary rules:
  - start_fcw ≥ stop_fcw: the load cycle sets `fcw`=start_fcw. On the first step, the clamp sets `fcw`=stop_fcw.
    - mode 0: `done`, IDLE.
    - mode 1: toggles between bounds each step.
  - step=0: `fcw` stays at start_fcw with no further `fcw_update`; the block remains busy until `abort`.
  - interval=0: a step every clock.
  - `start` while busy: ignored. `cfg_valid` while busy: stalled (`cfg_ready`=0).
- Reset values:
  - State IDLE.
  - `fcw`=0, `fcw_update`=0, `busy`=0, `done`=0.
  - `cfg_ready`=1 once reset deasserts.
  - Config registers all 0.

## Timing
- All outputs are registered; no combinational input→output paths except `cfg_ready` (decoded from state register only).
- `start` sampled at edge N:
  - `fcw`=start_fcw, `fcw_update`=1 and `busy`=1 from edge N.
  - First step at edge N+interval+1; subsequent steps every interval+1 edges.
- Final step to stop_fcw in mode 0: `fcw`=stop, `fcw_update`=1 and `done`=1 on the same edge; `busy`=0 from that edge.
- `abort` sampled at edge M: `busy`=0 from edge M; `cfg_ready`=1 from M.
- Reset assertion clears everything asynchronously mid-sweep.

## Test plan
- **Reset:** assert `reset_n`=0 mid-sweep → `fcw`=0, `busy`=0, `done`=0, `fcw_update`=0 immediately; `cfg_ready`=1 after release.
- **Single sweep:** start=0x000100, stop=0x000500, step=0x100, interval=3, mode 0.
  - `fcw` sequence 0x100,0x200,0x300,0x400,0x500, with updates 4 clocks apart.
  - `done` pulses with 0x500; 5 `fcw_update` pulses total.
- **Clamp:** start=0x10, stop=0x35, step=0x10, interval=0, mode 0 → `fcw` 0x10,0x20,0x30,0x35; `done` one cycle.
- **Triangle:** start=0x0, stop=0x30, step=0x10, interval=1, mode 1.
  - `fcw` 0,0x10,0x20,0x30,0x20,0x10,0,0x10…, steps every 2 clocks.
  - `busy` stays 1; `done` never pulses.
- **Abort + start same cycle mid-sweep at `fcw`=0x200:**
  - IDLE next cycle, `fcw` holds 0x200, no `done`.
  - `start` ignored; a new `start` one cycle later reloads start_fcw.
- **Handshake:** `cfg_valid` held while busy → `cfg_ready`=0, no latch. After `done`, the transfer completes and the next sweep uses the new values.

Source files
------------

// File: rtl/dds_sweep_controller.sv
// Linear chirp sequencer: drives the DDS accumulator FCW from start to stop in
// fixed steps at a programmable cadence, once or as a continuous triangle.
module dds_sweep_controller #(
  parameter int FCW_W = 24,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [FCW_W-1:0] cfg_start_fcw,
  input  logic [FCW_W-1:0] cfg_stop_fcw,
  input  logic [FCW_W-1:0] cfg_step,
  input  logic [DIV_W-1:0] cfg_interval,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             abort,
  output logic [FCW_W-1:0] fcw,
  output logic             fcw_update,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  typedef struct packed {
    logic [FCW_W-1:0] start_fcw;
    logic [FCW_W-1:0] stop_fcw;
    logic [FCW_W-1:0] step;
    logic [DIV_W-1:0] interval;
    logic             mode;
  } cfg_t;

  state_t           state_q, state_d;
  cfg_t             cfg_q, cfg_d, cfg_in, cfg_use;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [FCW_W-1:0] fcw_d;
  logic             upd_d, busy_d, done_d;
  logic             hs, tick;
  logic [FCW_W:0]   up_sum, dn_lim;
  logic [FCW_W-1:0] up_val, dn_val;

  assign cfg_ready = (state_q == IDLE);
  assign hs        = cfg_valid & cfg_ready;
  assign cfg_in    = '{start_fcw: cfg_start_fcw, stop_fcw: cfg_stop_fcw,
                       step: cfg_step, interval: cfg_interval, mode: cfg_mode};
  // a start coincident with a handshake must see the freshly offered config
  assign cfg_use   = hs ? cfg_in : cfg_q;
  assign tick      = (cnt_q == cfg_q.interval);

  // one extra bit on both compares so ramps near full scale cannot wrap
  assign up_sum = {1'b0, fcw} + {1'b0, cfg_q.step};
  assign dn_lim = {1'b0, cfg_q.start_fcw} + {1'b0, cfg_q.step};
  assign up_val = (up_sum >= {1'b0, cfg_q.stop_fcw}) ? cfg_q.stop_fcw : up_sum[FCW_W-1:0];
  assign dn_val = ({1'b0, fcw} <= dn_lim) ? cfg_q.start_fcw : fcw - cfg_q.step;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    fcw_d   = fcw;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) cfg_d = cfg_in;
        if (start && !abort) begin
          fcw_d   = cfg_use.start_fcw;
          upd_d   = 1'b1;
          cnt_d   = '0;
          state_d = UP;
        end
      end
      UP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick) begin
          cnt_d = '0;
          fcw_d = up_val;
          upd_d = (up_val != fcw);
          if (up_val == cfg_q.stop_fcw) begin
            if (cfg_q.mode) begin
              state_d = DOWN;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick) begin
          cnt_d = '0;
          fcw_d = dn_val;
          upd_d = (dn_val != fcw);
          if (dn_val == cfg_q.start_fcw) state_d = UP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      cnt_q      <= '0;
      fcw        <= '0;
      fcw_update <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      cnt_q      <= cnt_d;
      fcw        <= fcw_d;
      fcw_update <= upd_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Self-checking bench for dds_sweep_controller: vector table, directed corner
// sequences and randomized sweeps against a trajectory model.
module tb_dds_sweep_controller;
  localparam int FCW_W = 24;
  localparam int DIV_W = 16;
  localparam int T     = 48;

  typedef struct {
    logic [FCW_W-1:0] s, p, sp;
    logic [DIV_W-1:0] iv;
    logic             md;
  } cfg_t;

  typedef struct {
    cfg_t             c;
    logic             cv, st, ab;
    logic [FCW_W-1:0] efcw;
    logic             eupd, ebusy, edone, erdy;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [FCW_W-1:0] cfg_start_fcw = '0, cfg_stop_fcw = '0, cfg_step = '0;
  logic [DIV_W-1:0] cfg_interval = '0;
  logic             cfg_mode = 1'b0;
  logic             start = 1'b0, abort = 1'b0;
  logic [FCW_W-1:0] fcw;
  logic             fcw_update, busy, done;

  int checks = 0;
  int errors = 0;

  logic [FCW_W-1:0] e_fcw [T];
  bit               e_upd [T];
  bit               e_busy[T];
  bit               e_done[T];

  dds_sweep_controller #(.FCW_W(FCW_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_fcw(cfg_start_fcw), .cfg_stop_fcw(cfg_stop_fcw), .cfg_step(cfg_step),
    .cfg_interval(cfg_interval), .cfg_mode(cfg_mode), .start(start), .abort(abort),
    .fcw(fcw), .fcw_update(fcw_update), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_cfg(input cfg_t c);
    cfg_start_fcw = c.s;
    cfg_stop_fcw  = c.p;
    cfg_step      = c.sp;
    cfg_interval  = c.iv;
    cfg_mode      = c.md;
  endtask

  function automatic cfg_t mkc(input logic [FCW_W-1:0] s, p, sp, input logic [DIV_W-1:0] iv,
                               input logic md);
    cfg_t c;
    c.s = s; c.p = p; c.sp = sp; c.iv = iv; c.md = md;
    return c;
  endfunction

  function automatic vec_t mk(input cfg_t c, input logic cv, st, ab,
                              input logic [FCW_W-1:0] f, input logic u, b, d);
    vec_t v;
    v.c = c; v.cv = cv; v.st = st; v.ab = ab;
    v.efcw = f; v.eupd = u; v.ebusy = b; v.edone = d; v.erdy = !b;
    return v;
  endfunction

  // Expected per-cycle trajectory after the start edge (t=0): the ramp moves
  // toward the current target every iv+1 cycles, clamping at the bounds.
  task automatic build(input cfg_t c, input int ab);
    longint s, p, st, v, nv;
    bit up, live;
    s = c.s; p = c.p; st = c.sp; v = s; up = 1; live = 1;
    for (int t = 0; t < T; t++) begin
      e_upd[t] = 0; e_done[t] = 0;
      if (t == 0) begin
        v = s; e_upd[t] = 1;
      end else if (live && t == ab) begin
        live = 0;
      end else if (live && (t % (int'(c.iv) + 1)) == 0) begin
        if (up) nv = (v + st >= p) ? p : v + st;
        else    nv = (v <= s + st) ? s : v - st;
        e_upd[t] = (nv != v);
        v = nv;
        if (up && v == p) begin
          if (c.md) up = 0;
          else begin live = 0; e_done[t] = 1; end
        end else if (!up && v == s) begin
          up = 1;
        end
      end
      e_fcw[t]  = v[FCW_W-1:0];
      e_busy[t] = live;
    end
  endtask

  task automatic cmp_t(input int tr, input int t);
    chk($sformatf("rnd%0d.t%0d.fcw", tr, t), fcw, e_fcw[t]);
    chk($sformatf("rnd%0d.t%0d.upd", tr, t), fcw_update, e_upd[t]);
    chk($sformatf("rnd%0d.t%0d.busy", tr, t), busy, e_busy[t]);
    chk($sformatf("rnd%0d.t%0d.done", tr, t), done, e_done[t]);
    chk($sformatf("rnd%0d.t%0d.rdy", tr, t), cfg_ready, !e_busy[t]);
  endtask

  initial begin
    vec_t tbl[$];
    cfg_t cC, cT, cS, cA, cB;
    logic [FCW_W-1:0] vals[$];
    int ts[$];
    bit got_done;
    longint dval;

    cC = mkc('h10, 'h35, 'h10, 0, 0);
    cT = mkc('h0, 'h30, 'h10, 1, 1);
    cS = mkc('h100, 'h500, 'h100, 3, 0);
    cA = mkc('h100, 'h500, 'h100, 0, 0);
    cB = mkc('h40, 'h80, 'h20, 0, 0);

    tbl.push_back(mk(cC, 1, 1, 0, 'h10, 1, 1, 0));
    tbl.push_back(mk(cC, 0, 0, 0, 'h20, 1, 1, 0));
    tbl.push_back(mk(cC, 0, 0, 0, 'h30, 1, 1, 0));
    tbl.push_back(mk(cC, 0, 0, 0, 'h35, 1, 0, 1));
    tbl.push_back(mk(cC, 0, 0, 0, 'h35, 0, 0, 0));
    tbl.push_back(mk(cT, 1, 1, 0, 'h00, 1, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h00, 0, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h10, 1, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h10, 0, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h20, 1, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h20, 0, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h30, 1, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h30, 0, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h20, 1, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h20, 0, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h10, 1, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h10, 0, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h00, 1, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h00, 0, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 0, 'h10, 1, 1, 0));
    tbl.push_back(mk(cT, 0, 1, 0, 'h10, 0, 1, 0));
    tbl.push_back(mk(cT, 0, 0, 1, 'h10, 0, 0, 0));

    // reset state
    #2 reset_n = 1'b0;
    #5;
    chk("rst.fcw", fcw, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.upd", fcw_update, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst.rdy", cfg_ready, 1);

    // zeroed config: load 0, first step clamps to stop=0 and finishes
    start = 1; tick(); start = 0;
    chk("zcfg.load.fcw", fcw, 0);
    chk("zcfg.load.upd", fcw_update, 1);
    chk("zcfg.load.busy", busy, 1);
    tick();
    chk("zcfg.done", done, 1);
    chk("zcfg.busy", busy, 0);
    chk("zcfg.upd", fcw_update, 0);

    // vector table: clamp sweep then triangle ended by abort
    foreach (tbl[i]) begin
      drive_cfg(tbl[i].c);
      cfg_valid = tbl[i].cv; start = tbl[i].st; abort = tbl[i].ab;
      tick();
      chk($sformatf("vec%0d.fcw", i), fcw, tbl[i].efcw);
      chk($sformatf("vec%0d.upd", i), fcw_update, tbl[i].eupd);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].ebusy);
      chk($sformatf("vec%0d.done", i), done, tbl[i].edone);
      chk($sformatf("vec%0d.rdy", i), cfg_ready, tbl[i].erdy);
    end
    cfg_valid = 0; start = 0; abort = 0;

    // single sweep: 5 updates 4 clocks apart, done with the last
    drive_cfg(cS); cfg_valid = 1; start = 1; tick(); cfg_valid = 0; start = 0;
    got_done = 0; dval = 0;
    if (fcw_update) begin vals.push_back(fcw); ts.push_back(0); end
    for (int c = 1; c <= 40 && !got_done; c++) begin
      tick();
      if (fcw_update) begin vals.push_back(fcw); ts.push_back(c); end
      if (done) begin got_done = 1; dval = fcw; end
    end
    chk("single.done_seen", got_done, 1);
    chk("single.n_upd", vals.size(), 5);
    foreach (vals[i]) chk($sformatf("single.val%0d", i), vals[i], 'h100 * (i + 1));
    for (int i = 1; i < ts.size(); i++) chk($sformatf("single.gap%0d", i), ts[i] - ts[i-1], 4);
    chk("single.done_fcw", dval, 'h500);
    tick();
    chk("single.done_pulse", done, 0);
    chk("single.idle", busy, 0);

    // abort + start together mid-sweep
    start = 1; tick(); start = 0;
    for (int c = 0; c < 20 && fcw != 'h200; c++) tick();
    chk("abst.reach200", fcw, 'h200);
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    chk("abst.busy", busy, 0);
    chk("abst.fcw", fcw, 'h200);
    chk("abst.done", done, 0);
    chk("abst.upd", fcw_update, 0);
    chk("abst.rdy", cfg_ready, 1);
    start = 1; tick(); start = 0;
    chk("abst.reload.fcw", fcw, 'h100);
    chk("abst.reload.upd", fcw_update, 1);
    chk("abst.reload.busy", busy, 1);
    abort = 1; tick(); abort = 0;

    // config stalled while busy, accepted after done
    drive_cfg(cA); cfg_valid = 1; start = 1; tick(); start = 0;
    drive_cfg(cB);
    got_done = 0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (done) got_done = 1;
      else begin chk("hs.stall.rdy", cfg_ready, 0); tick(); end
    end
    chk("hs.done_seen", got_done, 1);
    chk("hs.old_stop", fcw, 'h500);
    chk("hs.rdy_after", cfg_ready, 1);
    tick(); cfg_valid = 0;
    start = 1; tick(); start = 0;
    chk("hs.new_start", fcw, 'h40);
    got_done = 0;
    for (int c = 0; c < 20 && !got_done; c++) begin tick(); if (done) got_done = 1; end
    chk("hs.new_done_seen", got_done, 1);
    chk("hs.new_stop", fcw, 'h80);

    // asynchronous reset mid-sweep
    drive_cfg(cS); cfg_valid = 1; start = 1; tick(); cfg_valid = 0; start = 0;
    tick(); tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst.fcw", fcw, 0);
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.upd", fcw_update, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("arst.rdy", cfg_ready, 1);
    chk("arst.idle", busy, 0);

    // randomized sweeps against the trajectory model
    for (int tr = 0; tr < 40; tr++) begin
      cfg_t c;
      int ab;
      bit same;
      case ($urandom % 4)
        0: begin
          c.s = FCW_W'($urandom_range(0, 'h300)); c.p = c.s + FCW_W'($urandom_range(0, 'h600));
          c.sp = FCW_W'($urandom_range(1, 'h180));
        end
        1: begin
          c.p = FCW_W'($urandom_range(0, 'h200)); c.s = c.p + FCW_W'($urandom_range(0, 'h100));
          c.sp = FCW_W'($urandom_range(0, 'h80));
        end
        2: begin
          c.s = FCW_W'($urandom_range(0, 'h100)); c.p = c.s + FCW_W'($urandom_range(1, 'h100));
          c.sp = '0;
        end
        default: begin
          c.s = FCW_W'('hFFFF00 - $urandom_range(0, 'h100));
          c.p = FCW_W'('hFFFFFF - $urandom_range(0, 'h20));
          c.sp = FCW_W'($urandom_range('h20, 'hC0));
        end
      endcase
      c.iv = DIV_W'($urandom_range(0, 3));
      c.md = 1'($urandom % 2);
      ab   = ($urandom % 2) ? int'($urandom_range(1, T - 1)) : 0;
      same = 1'($urandom % 2);
      abort = 1; tick(); abort = 0;
      build(c, ab);
      drive_cfg(c); cfg_valid = 1;
      if (!same) begin tick(); cfg_valid = 0; end
      start = 1; tick(); start = 0; cfg_valid = 0;
      cmp_t(tr, 0);
      for (int t = 1; t < T; t++) begin
        abort = (t == ab);
        tick();
        abort = 0;
        cmp_t(tr, t);
      end
    end
    abort = 1; tick(); abort = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
